apx_mul_eval_ctrl: RTL
======================

APX_MUL_EVAL_CTRL -- requirements
Module: apx_mul_eval_ctrl

Interface
REQ-001 SHALL have parameter OPW, default 8: multiplier operand width; product width is 2*OPW.
REQ-002 SHALL have parameter CNTW, default 16: sample-counter and error-counter width.
REQ-003 SHALL have parameter SUMW, default 32: width of the absolute-error-distance accumulator.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1: begin a characterization run; sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1: terminate the run in progress.
REQ-008 SHALL have port num_samples, input, CNTW: number of operand pairs to evaluate.
REQ-009 SHALL have port settle_cycles, input, 8: wait cycles before sampling the multiplier output.
REQ-010 SHALL have port seed, input, 16: initial LFSR state.
REQ-011 SHALL have port mul_a, output, OPW: operand A driven to the approximate multiplier.
REQ-012 SHALL have port mul_b, output, OPW: operand B driven to the approximate multiplier.
REQ-013 SHALL have port mul_o, input, 2*OPW: approximate product returned by the multiplier under test.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse marking run completion.
REQ-016 SHALL have port err_count, output, CNTW: number of samples where mul_o differs from the exact product.
REQ-017 SHALL have port sum_ed_abs, output, SUMW: sum of |exact - mul_o| over all samples.
REQ-018 SHALL have port max_ed, output, 2*OPW: maximum |exact - mul_o| seen in the run.
REQ-019 SHALL have port sample_idx, output, CNTW: number of samples completed in the current run.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, SETTLE, SAMPLE and DONE.
REQ-021 IDLE with start=1 SHALL load lfsr<=seed, clear err_count, sum_ed_abs, max_ed and sample_idx, then go to LOAD; if num_samples==0 it SHALL go to DONE instead.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 A seed of 16'h0000 SHALL be replaced by 16'hACE1.
REQ-024 LOAD SHALL register mul_a<=lfsr[OPW-1:0] and mul_b<=lfsr[2*OPW-1:OPW], advance the LFSR one step, load the settle counter, and go to SETTLE.
REQ-025 The LFSR SHALL be a 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1, shifting left with the feedback bit entering bit 0.
REQ-026 SETTLE SHALL last max(settle_cycles,1) cycles, then go to SAMPLE.
REQ-027 SAMPLE SHALL compute exact=mul_a*mul_b at full 2*OPW width and ed=|exact-mul_o|.
REQ-028 SAMPLE SHALL, if ed!=0, increment err_count.
REQ-029 SAMPLE SHALL add ed to sum_ed_abs, saturating at all-ones.
REQ-030 SAMPLE SHALL update max_ed<=max(max_ed,ed) and increment sample_idx.
REQ-031 SAMPLE SHALL go to DONE when the incremented sample_idx==num_samples, else to LOAD.
REQ-032 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-033 Results SHALL hold until the next accepted start.
REQ-034 Latency from the start cycle to the done cycle SHALL be N*(S+2)+1 cycles, where N=num_samples and S=max(settle_cycles,1); for N=0 the latency SHALL be 1.
REQ-035 num_samples, settle_cycles and seed SHALL be captured at start; changes during a run SHALL have no effect.
REQ-036 abort in any non-IDLE state SHALL force IDLE next cycle with no done pulse; partial results SHALL be retained.
REQ-037 abort and start asserted together in IDLE: start SHALL win.
REQ-038 In SAMPLE, abort SHALL take priority and the sample SHALL still be accumulated.

Reset
REQ-039 rst SHALL force IDLE, busy=0, done=0, mul_a=0, mul_b=0, err_count=0, sum_ed_abs=0, max_ed=0, sample_idx=0 and lfsr=16'hACE1.
REQ-040 rst SHALL override start and abort; reset mid-run SHALL discard the run with no done pulse.

Structure
REQ-041 State encoding, the LFSR tap mask, the zero-seed substitute 16'hACE1 and the default widths SHALL live in shared package apx_eval_pkg.
REQ-042 The LFSR SHALL be a separate sub-module apx_lfsr16 with ports clk, rst, load, seed, step and state.
REQ-043 The exact product SHALL be the single behavioral multiplier inside this block; no other arithmetic instances SHALL be used.

Verification
REQ-044 Run with num_samples=100, settle_cycles=4 and mul_o wired to an exact model: SHALL give err_count=0, sum_ed_abs=0, max_ed=0, and done exactly 601 cycles after start.
REQ-045 Run with seed=16'h0203, num_samples=1 and mul_o forced to 4: mul_a=3 and mul_b=2 SHALL be driven, giving err_count=1, sum_ed_abs=2, max_ed=2.
REQ-046 Run with num_samples=0: done SHALL occur 1 cycle after start with all results 0; run with seed=0 SHALL show first operands mul_a=8'hE1, mul_b=8'hAC.
REQ-047 Run with mul_o forced to 0, num_samples=1000 and settle_cycles=0: sum_ed_abs SHALL equal the sum of the products, each sample SHALL span 3 cycles, and max_ed SHALL be the largest product.
REQ-048 abort in cycle 50 of a 100-sample run: busy SHALL fall next cycle with no done pulse and sample_idx SHALL hold the partial count.
REQ-049 rst during SETTLE: all outputs SHALL be zero next cycle, and a start in the same cycle as rst SHALL be ignored.

Source files
------------

// File: rtl/apx_eval_pkg.sv
// Shared definitions for the approximate-multiplier evaluation controller:
// FSM state encoding, LFSR constants and default widths.
package apx_eval_pkg;

    localparam int DEF_OPW  = 8;
    localparam int DEF_CNTW = 16;
    localparam int DEF_SUMW = 32;

    // x^16 + x^14 + x^13 + x^11 + 1 on a left-shifting register:
    // feedback is the XOR of bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;

    // An all-zero state would lock the LFSR, so it is replaced by this value.
    localparam logic [15:0] LFSR_ZERO_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/apx_lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left with feedback entering bit 0.
// load has priority over step; a zero seed is substituted so the
// sequence can never stall.
module apx_lfsr16
    import apx_eval_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] state_reg;
    logic [15:0] state_next;
    logic [15:0] shifted;
    logic        feedback;

    assign feedback   = ^(state_reg & LFSR_TAPS);
    assign shifted[0] = feedback;

    genvar gi;
    generate
        for (gi = 1; gi < 16; gi++) begin : g_shift
            assign shifted[gi] = state_reg[gi-1];
        end
    endgenerate

    // Next state: reload from seed, advance one step, or hold.
    always_comb begin
        state_next = state_reg;
        if (load) begin
            state_next = (seed == 16'h0000) ? LFSR_ZERO_SEED : seed;
        end else if (step) begin
            state_next = shifted;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= LFSR_ZERO_SEED;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/apx_mul_eval_ctrl.sv
// Characterization controller for an approximate multiplier. Drives
// pseudo-random operand pairs, waits for the multiplier to settle,
// compares its product against an exact product and accumulates error
// statistics (error count, sum of |error|, maximum |error|).
module apx_mul_eval_ctrl
    import apx_eval_pkg::*;
#(
    parameter int OPW  = DEF_OPW,
    parameter int CNTW = DEF_CNTW,
    parameter int SUMW = DEF_SUMW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNTW-1:0]   num_samples,
    input  logic [7:0]        settle_cycles,
    input  logic [15:0]       seed,
    output logic [OPW-1:0]    mul_a,
    output logic [OPW-1:0]    mul_b,
    input  logic [2*OPW-1:0]  mul_o,
    output logic              busy,
    output logic              done,
    output logic [CNTW-1:0]   err_count,
    output logic [SUMW-1:0]   sum_ed_abs,
    output logic [2*OPW-1:0]  max_ed,
    output logic [CNTW-1:0]   sample_idx
);

    localparam int PW   = 2 * OPW;
    // Accumulator addition is done one bit wider than the larger operand
    // so that the carry-out reveals saturation for any SUMW/OPW pairing.
    localparam int ACCW = ((SUMW > PW) ? SUMW : PW) + 1;

    state_t          state_reg;
    state_t          state_next;

    logic            lfsr_load;
    logic            lfsr_step;
    logic [15:0]     lfsr_state;

    logic [OPW-1:0]  mul_a_reg;
    logic [OPW-1:0]  mul_b_reg;
    logic [CNTW-1:0] err_count_reg;
    logic [SUMW-1:0] sum_reg;
    logic [PW-1:0]   max_reg;
    logic [CNTW-1:0] sample_idx_reg;
    logic [CNTW-1:0] num_samples_reg;
    logic [7:0]      settle_reg;
    logic [7:0]      settle_cnt_reg;

    logic [7:0]      settle_eff;
    logic [PW-1:0]   exact;
    logic [PW-1:0]   ed;
    logic [ACCW-1:0] sum_wide;
    logic [SUMW-1:0] sum_sat;
    logic [CNTW-1:0] idx_inc;

    apx_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (seed),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // A settle time of zero still needs one cycle so the operands reach mul_o.
    assign settle_eff = (settle_reg == 8'd0) ? 8'd1 : settle_reg;

    // Error metrics for the operands currently on mul_a/mul_b.
    always_comb begin
        exact    = PW'(mul_a_reg) * PW'(mul_b_reg);
        ed       = (exact >= mul_o) ? (exact - mul_o) : (mul_o - exact);
        sum_wide = ACCW'(sum_reg) + ACCW'(ed);
        sum_sat  = (sum_wide > ACCW'({SUMW{1'b1}})) ? {SUMW{1'b1}} : sum_wide[SUMW-1:0];
        idx_inc  = sample_idx_reg + CNTW'(1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and LFSR control; abort returns to IDLE from any busy state.
    always_comb begin
        state_next = state_reg;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    lfsr_load  = 1'b1;
                    state_next = (num_samples == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                lfsr_step  = 1'b1;
                state_next = abort ? ST_IDLE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (settle_cnt_reg <= 8'd1) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (idx_inc == num_samples_reg) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Run parameters, operand registers and result accumulators. A sample
    // is accumulated in SAMPLE even when abort arrives in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a_reg       <= '0;
            mul_b_reg       <= '0;
            err_count_reg   <= '0;
            sum_reg         <= '0;
            max_reg         <= '0;
            sample_idx_reg  <= '0;
            num_samples_reg <= '0;
            settle_reg      <= '0;
            settle_cnt_reg  <= '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        num_samples_reg <= num_samples;
                        settle_reg      <= settle_cycles;
                        err_count_reg   <= '0;
                        sum_reg         <= '0;
                        max_reg         <= '0;
                        sample_idx_reg  <= '0;
                    end
                end
                ST_LOAD: begin
                    mul_a_reg      <= lfsr_state[OPW-1:0];
                    mul_b_reg      <= lfsr_state[2*OPW-1:OPW];
                    settle_cnt_reg <= settle_eff;
                end
                ST_SETTLE: begin
                    settle_cnt_reg <= settle_cnt_reg - 8'd1;
                end
                ST_SAMPLE: begin
                    if (ed != '0) begin
                        err_count_reg <= err_count_reg + CNTW'(1);
                    end
                    sum_reg        <= sum_sat;
                    max_reg        <= (ed > max_reg) ? ed : max_reg;
                    sample_idx_reg <= idx_inc;
                end
                default: begin
                end
            endcase
        end
    end

    assign mul_a      = mul_a_reg;
    assign mul_b      = mul_b_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_DONE);
    assign err_count  = err_count_reg;
    assign sum_ed_abs = sum_reg;
    assign max_ed     = max_reg;
    assign sample_idx = sample_idx_reg;

endmodule
